// File: rtl/mvau_defn.sv
// Shared MVAU definitions: default layer geometry, derived weight-memory
// constants and the weight streamer's FSM state and tile tag types.
package mvau_defn;

    localparam int unsigned MATRIX_W  = 8;
    localparam int unsigned MATRIX_H  = 4;
    localparam int unsigned SIMD_DEF  = 2;
    localparam int unsigned PE_DEF    = 2;
    localparam int unsigned TW_DEF    = 4;
    localparam int unsigned REP_W_DEF = 16;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned SF         = MATRIX_W / SIMD_DEF;
    localparam int unsigned NF         = MATRIX_H / PE_DEF;
    localparam int unsigned SF_T       = clog2_min1(SF);
    localparam int unsigned NF_T       = clog2_min1(NF);
    localparam int unsigned WMEM_DEPTH = SF * NF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } wstrm_state_e;

    // Per-tile markers that travel through the skid buffer with the weights.
    typedef struct packed {
        logic sf_last;
        logic nf_last;
        logic fin;
    } tile_tag_t;

endpackage

// File: rtl/mvau_wgt_streamer_if.sv
// Weight tile stream towards the MVAU in_wgt port (ready/valid).
interface mvau_wgt_streamer_if #(
    parameter int unsigned SIMD = 2,
    parameter int unsigned PE   = 2,
    parameter int unsigned TW   = 4
);
    logic                 out_v;
    logic                 out_rdy;
    logic [0:SIMD*TW-1]   out_wgt [0:PE-1];
    logic                 out_sf_last;
    logic                 out_nf_last;

    modport master (output out_v, output out_wgt, output out_sf_last,
                    output out_nf_last, input out_rdy);
    modport slave  (input out_v, input out_wgt, input out_sf_last,
                    input out_nf_last, output out_rdy);
endinterface

// File: rtl/mvau_wgt_mem.sv
// One PE weight bank: simple dual-port RAM, synchronous write and read.
module mvau_wgt_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wen_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             ren_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wen_i) mem_q[waddr_i] <= wdata_i;
    end

    // Read register doubles as the main output slot, so it clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rdata_o <= '0;
        else if (ren_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/mvau_wgt_streamer.sv
// Replays the per-PE weight banks as a tile stream (sf, then nf, then rep)
// behind a 2-entry skid buffer with ready/valid flow control.
module mvau_wgt_streamer
    import mvau_defn::*;
#(
    parameter int unsigned MatrixW = MATRIX_W,
    parameter int unsigned MatrixH = MATRIX_H,
    parameter int unsigned SIMD    = SIMD_DEF,
    parameter int unsigned PE      = PE_DEF,
    parameter int unsigned TW      = TW_DEF,
    parameter int unsigned REP_W   = REP_W_DEF
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             wmem_wen,
    input  logic [clog2_min1(PE)-1:0]                        wmem_pe,
    input  logic [clog2_min1((MatrixW/SIMD)*(MatrixH/PE))-1:0] wmem_addr,
    input  logic [SIMD*TW-1:0]                               wmem_din,
    input  logic                                             start,
    input  logic [REP_W-1:0]                                 num_reps,
    mvau_wgt_streamer_if.master                              strm,
    output logic                                             busy,
    output logic                                             done
);
    localparam int unsigned SF_N  = MatrixW / SIMD;
    localparam int unsigned NF_N  = MatrixH / PE;
    localparam int unsigned DEPTH = SF_N * NF_N;
    localparam int unsigned AW    = clog2_min1(DEPTH);
    localparam int unsigned SFW   = clog2_min1(SF_N);
    localparam int unsigned NFW   = clog2_min1(NF_N);
    localparam int unsigned PEW   = clog2_min1(PE);
    localparam int unsigned WW    = SIMD * TW;

    wstrm_state_e         state_q;
    logic [SFW-1:0]       sf_q;
    logic [NFW-1:0]       nf_q;
    logic [REP_W-1:0]     rep_q, reps_q;
    logic                 busy_q, done_q;

    logic [PE-1:0][WW-1:0] rdata_w;
    logic [PE-1:0][WW-1:0] s_wgt_q, s_wgt_d;
    logic                  m_v_q, m_v_d, s_v_q, s_v_d;
    tile_tag_t             m_tag_q, m_tag_d, s_tag_q, s_tag_d, rd_tag, out_tag;

    logic                  out_v_w, pop, pop_m, m_keep, rd_en;
    logic                  sf_wrap, nf_wrap, rep_last;
    logic [1:0]            occ;
    logic [AW-1:0]         rd_addr;

    assign sf_wrap  = (sf_q == SFW'(SF_N - 1));
    assign nf_wrap  = (nf_q == NFW'(NF_N - 1));
    assign rep_last = (rep_q == reps_q - REP_W'(1));
    assign rd_addr  = AW'(nf_q) * AW'(SF_N) + AW'(sf_q);

    always_comb begin
        rd_tag         = '0;
        rd_tag.sf_last = sf_wrap;
        rd_tag.nf_last = sf_wrap && nf_wrap;
        rd_tag.fin     = sf_wrap && nf_wrap && rep_last;
    end

    // Data returns the next cycle straight into the read register, so the only
    // credit question is whether a slot is free after this cycle's pop.
    assign out_v_w = s_v_q || m_v_q;
    assign pop     = out_v_w && strm.out_rdy;
    assign occ     = {1'b0, s_v_q} + {1'b0, m_v_q};
    assign rd_en   = (state_q == RUN) && ((occ != 2'd2) || pop);

    for (genvar p = 0; p < PE; p++) begin : g_bank
        mvau_wgt_mem #(.DEPTH(DEPTH), .WIDTH(WW), .AW(AW)) u_mem (
            .clk     (clk),
            .rst_n   (rst_n),
            .wen_i   (wmem_wen && (state_q == IDLE) && (wmem_pe == PEW'(p))),
            .waddr_i (wmem_addr),
            .wdata_i (wmem_din),
            .ren_i   (rd_en),
            .raddr_i (rd_addr),
            .rdata_o (rdata_w[p])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sf_q    <= '0;
            nf_q    <= '0;
            rep_q   <= '0;
            reps_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (num_reps != '0) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            sf_q    <= '0;
                            nf_q    <= '0;
                            rep_q   <= '0;
                            reps_q  <= num_reps;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (rd_en) begin
                        if (sf_wrap) begin
                            sf_q <= '0;
                            if (nf_wrap) begin
                                nf_q  <= '0;
                                rep_q <= rep_q + 1'b1;
                            end else begin
                                nf_q <= nf_q + 1'b1;
                            end
                        end else begin
                            sf_q <= sf_q + 1'b1;
                        end
                        if (rd_tag.fin) state_q <= DRAIN;
                    end
                end
                default: ;
            endcase
            if ((state_q != IDLE) && pop && out_tag.fin) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end
    end

    // Skid slot holds the older tile; a new read evicts an unsent main tile into it.
    always_comb begin
        pop_m   = pop && !s_v_q;
        m_keep  = m_v_q && !pop_m;
        s_v_d   = s_v_q && !(pop && s_v_q);
        s_wgt_d = s_wgt_q;
        s_tag_d = s_tag_q;
        m_v_d   = m_keep;
        m_tag_d = m_tag_q;
        if (rd_en) begin
            m_v_d   = 1'b1;
            m_tag_d = rd_tag;
            if (m_keep) begin
                s_v_d   = 1'b1;
                s_wgt_d = rdata_w;
                s_tag_d = m_tag_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_v_q   <= 1'b0;
            s_v_q   <= 1'b0;
            m_tag_q <= '0;
            s_tag_q <= '0;
        end else begin
            m_v_q   <= m_v_d;
            s_v_q   <= s_v_d;
            m_tag_q <= m_tag_d;
            s_tag_q <= s_tag_d;
        end
    end

    always_ff @(posedge clk) begin
        s_wgt_q <= s_wgt_d;
    end

    always_comb begin
        out_tag          = s_v_q ? s_tag_q : m_tag_q;
        strm.out_v       = out_v_w;
        strm.out_sf_last = out_v_w && out_tag.sf_last;
        strm.out_nf_last = out_v_w && out_tag.nf_last;
        for (int p = 0; p < PE; p++) begin
            strm.out_wgt[p] = s_v_q ? s_wgt_q[p] : rdata_w[p];
        end
    end

    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_mvau_wgt_streamer.sv
// Directed bench for mvau_wgt_streamer: SF=4, NF=2, PE=2, SIMD=2, TW=4.
module tb_mvau_wgt_streamer;
    localparam int unsigned SIMD = 2;
    localparam int unsigned PE   = 2;
    localparam int unsigned TW   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wmem_wen = 1'b0;
    logic [0:0]  wmem_pe = '0;
    logic [2:0]  wmem_addr = '0;
    logic [7:0]  wmem_din = '0;
    logic        start = 1'b0;
    logic [15:0] num_reps = '0;
    logic        busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mvau_wgt_streamer_if #(.SIMD(SIMD), .PE(PE), .TW(TW)) strm ();

    mvau_wgt_streamer #(
        .MatrixW(8), .MatrixH(4), .SIMD(SIMD), .PE(PE), .TW(TW), .REP_W(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wmem_wen  (wmem_wen),
        .wmem_pe   (wmem_pe),
        .wmem_addr (wmem_addr),
        .wmem_din  (wmem_din),
        .start     (start),
        .num_reps  (num_reps),
        .strm      (strm),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One run: full rate or random ready, optional mid-run pokes, optional reset.
    task automatic run(input int reps, input bit rnd, input bit poke,
                       input int rst_at, input string nm);
        int  k, done_j, first_v, busy_n;
        bit  stall_prev;
        k = 0; done_j = -1; first_v = -1; busy_n = 0; stall_prev = 1'b0;
        @(negedge clk);
        start = 1'b1; num_reps = 16'(reps); strm.out_rdy = 1'b1;
        for (int j = 1; j <= 16 * reps + 40 && done_j < 0; j++) begin
            @(negedge clk);
            if (j == 1) start = 1'b0;
            if (poke && j == 5) begin
                start = 1'b1; num_reps = 16'd1;
                wmem_wen = 1'b1; wmem_pe = 1'b0; wmem_addr = 3'd2; wmem_din = 8'hFF;
            end
            if (poke && j == 6) begin
                start = 1'b0; wmem_wen = 1'b0;
            end
            busy_n += int'(busy);
            if (done) done_j = j;
            if (stall_prev) chk({nm, "_hold_v"}, 32'(strm.out_v), 32'd1);
            if (strm.out_v) begin
                int a;
                a = k % 8;
                if (first_v < 0) first_v = j;
                chk({nm, "_pe0"}, 32'(strm.out_wgt[0]), 32'(a));
                chk({nm, "_pe1"}, 32'(strm.out_wgt[1]), 32'(16 + a));
                chk({nm, "_sfl"}, 32'(strm.out_sf_last), 32'(a % 4 == 3));
                chk({nm, "_nfl"}, 32'(strm.out_nf_last), 32'(a == 7));
                if (rst_at >= 0 && k == rst_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk({nm, "_rst_v"}, 32'(strm.out_v), 32'd0);
                    chk({nm, "_rst_busy"}, 32'(busy), 32'd0);
                    chk({nm, "_rst_wgt"}, 32'({strm.out_wgt[0], strm.out_wgt[1]}), 32'd0);
                    chk({nm, "_rst_flags"}, 32'({strm.out_sf_last, strm.out_nf_last}), 32'd0);
                    repeat (2) @(negedge clk);
                    chk({nm, "_rst_hold"}, 32'({strm.out_v, busy, done}), 32'd0);
                    rst_n = 1'b1;
                    strm.out_rdy = 1'b1;
                    return;
                end
            end
            strm.out_rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            stall_prev = strm.out_v && !strm.out_rdy;
            if (strm.out_v && strm.out_rdy) k++;
        end
        chk({nm, "_handshakes"}, 32'(k), 32'(8 * reps));
        chk({nm, "_done_seen"}, 32'(done_j > 0), 32'd1);
        if (!rnd) begin
            chk({nm, "_first_v"}, 32'(first_v), 32'd2);
            chk({nm, "_done_cyc"}, 32'(done_j), 32'(2 + 8 * reps));
            chk({nm, "_busy_cyc"}, 32'(busy_n), 32'(8 * reps + 1));
        end
        strm.out_rdy = 1'b1;
        @(negedge clk);
        chk({nm, "_post"}, 32'({done, busy, strm.out_v}), 32'd0);
    endtask

    initial begin
        strm.out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_v", 32'(strm.out_v), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_flags", 32'({strm.out_sf_last, strm.out_nf_last}), 32'd0);
        chk("reset_wgt", 32'({strm.out_wgt[0], strm.out_wgt[1]}), 32'd0);
        rst_n = 1'b1;

        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < 8; a++) begin
                @(negedge clk);
                wmem_wen = 1'b1; wmem_pe = 1'(p); wmem_addr = 3'(a);
                wmem_din = {4'(p), 4'(a)};
            end
        end
        @(negedge clk);
        wmem_wen = 1'b0;

        run(1, 1'b0, 1'b0, -1, "single");
        run(3, 1'b0, 1'b0, -1, "reps");
        run(1, 1'b1, 1'b0, -1, "bp");
        run(2, 1'b1, 1'b0, -1, "bp2");

        @(negedge clk);
        start = 1'b1; num_reps = 16'd0;
        @(negedge clk);
        start = 1'b0;
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_v", 32'(strm.out_v), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("zero_quiet", 32'({done, busy, strm.out_v}), 32'd0);
        end

        run(2, 1'b0, 1'b1, -1, "poke");
        run(1, 1'b0, 1'b0, 2, "rst");
        run(1, 1'b0, 1'b0, -1, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
